mm_sequencer: RTL and testbench

//  Sequences one matrix job through the X-load / ALU / result-store datapath: counts X bytes in,

---
 rtl/mm_seq_pkg.sv | 17 +
 rtl/mm_seq_rd_arb.sv | 26 ++
 rtl/mm_sequencer.sv | 157 +++++++++++++++
 tb/tb_mm_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_seq_pkg.sv
// Shared types and default sizes for the matrix-job sequencer.
package mm_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        STORE,
        DONE
    } mm_state_e;

    localparam int X_WORDS_DEF   = 32;
    localparam int RES_WORDS_DEF = 32;
    localparam int ADDR_W_DEF    = 8;
    localparam int WDOG_CYC_DEF  = 1023;

endpackage

// File: rtl/mm_seq_rd_arb.sv
// Host read grant and SRAM address mux: host reads win only while the sequencer is idle.
module mm_seq_rd_arb
    import mm_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              read_n,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              rd_window,
    input  logic              store_act,
    input  logic [ADDR_W-1:0] store_addr,
    output logic              ry,
    output logic [ADDR_W-1:0] mem_addr
);

    always_comb begin
        ry       = ~read_n & rd_window;
        mem_addr = '0;
        if (ry) begin
            mem_addr = r_addr;
        end else if (store_act) begin
            mem_addr = store_addr;
        end
    end

endmodule

// File: rtl/mm_sequencer.sv
// Matrix job sequencer: X load, ALU run, result store, then host read arbitration.
// Optional compute watchdog enabled by defining MM_SEQ_WDOG_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start_in; host reads allowed
// LOAD    | capturing X_WORDS bytes from the pad
// COMPUTE | ALU running until alu_done (or watchdog expiry)
// STORE   | writing RES_WORDS results to SRAM, addresses 0..RES_WORDS-1
// DONE    | job finished, finish held; host reads allowed, start_in restarts
module mm_sequencer
    import mm_seq_pkg::*;
#(
    parameter int X_WORDS   = X_WORDS_DEF,
    parameter int RES_WORDS = RES_WORDS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int WDOG_CYC  = WDOG_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              valid_input,
    input  logic              read_n,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              alu_done,
    output logic              input_load_en,
    output logic              xload_done,
    output logic              alu_en,
    output logic              web,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ry,
    output logic              busy,
    output logic              finish,
    output logic              err
);

    localparam int XC_W = (X_WORDS > 1) ? $clog2(X_WORDS) : 1;
    localparam logic [XC_W-1:0]   X_LAST   = XC_W'(X_WORDS - 1);
    localparam logic [ADDR_W-1:0] RES_LAST = ADDR_W'(RES_WORDS - 1);

    mm_state_e         state, state_nx;
    logic [XC_W-1:0]   x_cnt, x_cnt_nx;
    logic [ADDR_W-1:0] st_cnt, st_cnt_nx;
    logic              finish_nx, err_nx, xload_nx;

`ifdef MM_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC - 1);
    logic [WD_W-1:0] wdog_cnt, wdog_nx;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYC;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            x_cnt      <= '0;
            st_cnt     <= '0;
            finish     <= 1'b0;
            err        <= 1'b0;
            xload_done <= 1'b0;
`ifdef MM_SEQ_WDOG_EN
            wdog_cnt   <= '0;
`endif
        end else begin
            state      <= state_nx;
            x_cnt      <= x_cnt_nx;
            st_cnt     <= st_cnt_nx;
            finish     <= finish_nx;
            err        <= err_nx;
            xload_done <= xload_nx;
`ifdef MM_SEQ_WDOG_EN
            wdog_cnt   <= wdog_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        x_cnt_nx  = x_cnt;
        st_cnt_nx = st_cnt;
        finish_nx = finish;
        err_nx    = err;
        xload_nx  = 1'b0;
`ifdef MM_SEQ_WDOG_EN
        wdog_nx   = wdog_cnt;
`endif
        case (state)
            IDLE, DONE: begin
                if (start_in) begin
                    state_nx  = LOAD;
                    finish_nx = 1'b0;
                    x_cnt_nx  = '0;
                end
            end
            LOAD: begin
                if (valid_input) begin
                    if (x_cnt == X_LAST) begin
                        state_nx = COMPUTE;
                        xload_nx = 1'b1;
`ifdef MM_SEQ_WDOG_EN
                        wdog_nx  = WD_LOAD;
`endif
                    end else begin
                        x_cnt_nx = x_cnt + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (alu_done) begin
                    state_nx  = STORE;
                    st_cnt_nx = '0;
                end
`ifdef MM_SEQ_WDOG_EN
                // Terminal count reached on the WDOG_CYC-th compute cycle: abort, skip STORE.
                else if (wdog_cnt == '0) begin
                    state_nx  = DONE;
                    finish_nx = 1'b1;
                    err_nx    = 1'b1;
                end else begin
                    wdog_nx = wdog_cnt - 1'b1;
                end
`endif
            end
            STORE: begin
                if (st_cnt == RES_LAST) begin
                    state_nx  = DONE;
                    finish_nx = 1'b1;
                end else begin
                    st_cnt_nx = st_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start_in && busy) begin
            err_nx = 1'b1;
        end
    end

    assign busy          = (state == LOAD) || (state == COMPUTE) || (state == STORE);
    assign input_load_en = (state == LOAD);
    assign alu_en        = (state == COMPUTE);
    assign web           = (state != STORE);

    mm_seq_rd_arb #(
        .ADDR_W(ADDR_W)
    ) u_rd_arb (
        .read_n    (read_n),
        .r_addr    (r_addr),
        .rd_window ((state == IDLE) || (state == DONE)),
        .store_act (state == STORE),
        .store_addr(st_cnt),
        .ry        (ry),
        .mem_addr  (mem_addr)
    );

endmodule

// File: tb/tb_mm_sequencer.sv
// Bench for mm_sequencer: job-level reference model checked every cycle, directed jobs, random traffic.
module tb_mm_sequencer;

    localparam int XW = 32;
    localparam int RW = 32;
    localparam int AW = 8;
`ifdef MM_SEQ_WDOG_EN
    localparam int WDC     = 15;
    localparam int ALU_DLY = 5;
`else
    localparam int WDC     = 1023;
    localparam int ALU_DLY = 20;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_in = 1'b0;
    logic valid_input = 1'b0;
    logic read_n = 1'b1;
    logic alu_done = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic input_load_en, xload_done, alu_en, web, ry, busy, finish, err;
    logic [AW-1:0] mem_addr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mm_sequencer #(
        .X_WORDS(XW), .RES_WORDS(RW), .ADDR_W(AW), .WDOG_CYC(WDC)
    ) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .valid_input(valid_input),
        .read_n(read_n), .r_addr(r_addr), .alu_done(alu_done),
        .input_load_en(input_load_en), .xload_done(xload_done), .alu_en(alu_en),
        .web(web), .mem_addr(mem_addr), .ry(ry), .busy(busy), .finish(finish), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase of the job plus how many bytes/results have gone by.
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMP = 2, P_STORE = 3, P_DONE = 4;
    int m_ph = P_IDLE;
    int m_bytes = 0;
    int m_idx = 0;
    int m_wd = 0;
    bit m_fin = 1'b0, m_err = 1'b0, m_xd = 1'b0;

    function automatic bit in_job(input int ph);
        return (ph == P_LOAD) || (ph == P_COMP) || (ph == P_STORE);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_ph = P_IDLE; m_bytes = 0; m_idx = 0; m_wd = 0;
                m_fin = 1'b0; m_err = 1'b0; m_xd = 1'b0;
            end else begin
                m_xd = 1'b0;
                if (start_in && in_job(m_ph)) m_err = 1'b1;
                case (m_ph)
                    P_IDLE, P_DONE: if (start_in) begin
                        m_ph = P_LOAD; m_fin = 1'b0; m_bytes = 0;
                    end
                    P_LOAD: if (valid_input) begin
                        m_bytes++;
                        if (m_bytes == XW) begin
                            m_ph = P_COMP; m_xd = 1'b1; m_wd = 0;
                        end
                    end
                    P_COMP: if (alu_done) begin
                        m_ph = P_STORE; m_idx = 0;
                    end
`ifdef MM_SEQ_WDOG_EN
                    else begin
                        m_wd++;
                        if (m_wd == WDC) begin
                            m_ph = P_DONE; m_fin = 1'b1; m_err = 1'b1;
                        end
                    end
`endif
                    P_STORE: begin
                        m_idx++;
                        if (m_idx == RW) begin
                            m_ph = P_DONE; m_fin = 1'b1;
                        end
                    end
                    default: m_ph = P_IDLE;
                endcase
            end
        end
    end

    initial begin
        logic [15:0] exp_v, act_v;
        logic e_ry;
        logic [AW-1:0] e_addr;
        forever begin
            @(negedge clk);
            e_ry   = !read_n && (m_ph == P_IDLE || m_ph == P_DONE);
            e_addr = e_ry ? r_addr : ((m_ph == P_STORE) ? AW'(m_idx) : '0);
            exp_v  = {m_ph == P_LOAD, m_xd, m_ph == P_COMP, m_ph != P_STORE, e_addr,
                      e_ry, in_job(m_ph), m_fin, m_err};
            act_v  = {input_load_en, xload_done, alu_en, web, mem_addr, ry, busy, finish, err};
            chk("outputs_vs_model", 32'(act_v), 32'(exp_v));
        end
    end

    int o_web, o_seq_bad, o_xd, o_alu, o_ry;

    task automatic clr_obs();
        o_web = 0; o_seq_bad = 0; o_xd = 0; o_alu = 0; o_ry = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (!web) begin
            if (mem_addr !== AW'(o_web)) o_seq_bad++;
            o_web++;
        end
        if (xload_done) o_xd++;
        if (alu_en) o_alu++;
        if (ry) o_ry++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_finish(input string nm, input int lim);
        int n = 0;
        while (!finish && n < lim) begin
            tick();
            n++;
        end
        chk(nm, 32'(finish), 1);
    endtask

    initial begin
        bit found;
        clr_obs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        repeat (10) begin
            @(negedge clk);
            chk("idle_outputs", 32'({web, busy, finish, err, ry, alu_en, input_load_en, xload_done, mem_addr}),
                32'h8000);
        end
        @(posedge clk);
        #1;

        // Job 1: gapped bytes, start during LOAD, host read attempts during STORE.
        clr_obs();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int b = 0; b < XW; b++) begin
            valid_input = 1'b1;
            start_in = (b == 5);
            tick();
            valid_input = 1'b0;
            start_in = 1'b0;
            repeat (3) tick();
        end
        chk("err_start_in_load", 32'(err), 1);
        repeat (ALU_DLY) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        read_n = 1'b0;
        r_addr = 8'hA5;
        wait_finish("job1_finish", 100);
        read_n = 1'b1;
        chk("job1_xload_pulses", o_xd, 1);
        chk("job1_alu_cycles", o_alu, 3 + ALU_DLY + 1);
        chk("job1_store_writes", o_web, RW);
        chk("job1_store_addr_seq", o_seq_bad, 0);
        chk("job1_ry_while_busy", o_ry, 0);
        chk("job1_busy_done", 32'(busy), 0);

        // Read and start in the same DONE cycle.
        read_n = 1'b0;
        r_addr = 8'h1F;
        start_in = 1'b1;
        @(negedge clk);
        chk("done_read_grant", 32'({ry, mem_addr}), 32'h11F);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        read_n = 1'b1;
        chk("start_from_done", 32'({busy, finish, input_load_en}), 32'b101);

        // Job 2: reset in the middle of STORE.
        clr_obs();
        valid_input = 1'b1;
        repeat (XW) tick();
        valid_input = 1'b0;
        repeat (2) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (!web && mem_addr == 8'd10) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("store_addr10_seen", 32'(found), 1);
        #2 rst = 1'b0;
        #1 chk("reset_mid_store", 32'({web, busy, finish, err, alu_en, mem_addr}), 32'h1000);
        @(posedge clk);
        #1 rst = 1'b1;

        // Job 3: clean job after the reset.
        clr_obs();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int b = 0; b < XW; b++) begin
            valid_input = 1'b1;
            tick();
            valid_input = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat ($urandom_range(0, ALU_DLY)) tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        wait_finish("job3_finish", 100);
        chk("job3_store_writes", o_web, RW);
        chk("job3_err_clear", 32'(err), 0);

`ifdef MM_SEQ_WDOG_EN
        clr_obs();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        valid_input = 1'b1;
        repeat (XW) tick();
        valid_input = 1'b0;
        wait_finish("wdog_finish", 100);
        chk("wdog_alu_cycles", o_alu, WDC);
        chk("wdog_err", 32'(err), 1);
        chk("wdog_no_store", o_web, 0);
`endif

        // Random traffic, including occasional resets.
        for (int i = 0; i < 4000; i++) begin
            start_in    = ($urandom % 40) == 0;
            valid_input = ($urandom % 3) == 0;
            read_n      = ($urandom % 2) == 0;
            r_addr      = AW'($urandom);
            alu_done    = ($urandom % 12) == 0;
            if (($urandom % 600) == 0) rst = 1'b0;
            tick();
            rst = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
